// File: rtl/video_timing_pkg.sv
// Shared constants, totals helpers and phase encoding for the 480p raster generator.
package video_timing_pkg;

    // Counter and frame-counter widths seen on the output ports.
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned FRAME_W   = 8;
    localparam int unsigned MAX_TOTAL = 1024;

    // 640x480@60 Hz defaults (800x525 raster at 25.2 MHz).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Sync polarity: value driven while sync is active.
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;
    localparam logic DEF_HS_POL      = POL_ACTIVE_LOW;
    localparam logic DEF_VS_POL      = POL_ACTIVE_LOW;

    // Phase of one raster axis.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    // Total counts per axis.
    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_480p_axis.sv
// Generic wrap counter for one raster axis with a phase FSM tracking ACT/FP/SYN/BP.
// Outputs are the values the counter and phase will take after the next edge.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             clear,
    output logic [CNT_W-1:0] count_next_c,
    output phase_e           phase_next_c,
    output logic             wrap_c
);

    localparam int unsigned TOTAL = h_total(ACTIVE, FP, SYNC, BP);

    // Last index of each phase.
    localparam logic [CNT_W-1:0] L_ACT = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] L_FP  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] L_SYN = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] L_BP  = CNT_W'(TOTAL - 1);

    // Every phase needs at least one count for the FSM transitions to be well-formed.
    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_chk
        $error("timing_axis_counter: every phase length must be at least 1");
    end

    if (TOTAL > MAX_TOTAL) begin : g_total_chk
        $error("timing_axis_counter: axis total exceeds counter range");
    end

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    // Next count, wrap detect and phase transitions at the last index of each phase.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap_c  = advance && !clear && (count_q == L_BP);
        if (clear) begin
            count_d = '0;
            phase_d = PH_ACT;
        end else if (advance) begin
            count_d = wrap_c ? '0 : count_q + CNT_W'(1);
            case (phase_q)
                PH_ACT:  if (count_q == L_ACT) phase_d = PH_FP;
                PH_FP:   if (count_q == L_FP)  phase_d = PH_SYN;
                PH_SYN:  if (count_q == L_SYN) phase_d = PH_BP;
                PH_BP:   if (count_q == L_BP)  phase_d = PH_ACT;
                default: phase_d = PH_ACT;
            endcase
        end
    end

    // Count and phase state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= PH_ACT;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count_next_c = count_d;
    assign phase_next_c = phase_d;

endmodule

// File: rtl/video_timing_480p.sv
// 640x480@60 raster timing generator: syncs, data-enable, coordinates and strobes,
// all registered and decoded from next-state counter values so they line up with X/Y.
module video_timing_480p
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = DEF_HS_POL,
    parameter logic        VS_POL   = DEF_VS_POL
) (
    input  logic               PCLK,
    input  logic               RESET_n,
    input  logic               LOCK,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DE,
    output logic [CNT_W-1:0]   X,
    output logic [CNT_W-1:0]   Y,
    output logic               LINE_START,
    output logic               FRAME_START,
    output logic [FRAME_W-1:0] FRAME_CNT
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
        $error("video_timing_480p: raster total exceeds 1024");
    end

    logic               run_q, run_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0]   h_cnt_next_c, v_cnt_next_c;
    phase_e             h_phase_next_c, v_phase_next_c;
    logic               h_wrap_c, v_wrap_c;

    // Horizontal axis: advances every clock once running; held at 0 while LOCK is low.
    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk          (PCLK),
        .rst_n        (RESET_n),
        .advance      (run_q),
        .clear        (~LOCK),
        .count_next_c (h_cnt_next_c),
        .phase_next_c (h_phase_next_c),
        .wrap_c       (h_wrap_c)
    );

    // Vertical axis: advances on each line wrap.
    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk          (PCLK),
        .rst_n        (RESET_n),
        .advance      (h_wrap_c),
        .clear        (~LOCK),
        .count_next_c (v_cnt_next_c),
        .phase_next_c (v_phase_next_c),
        .wrap_c       (v_wrap_c)
    );

    // Output decode from next-state values; everything idles while not running.
    always_comb begin
        run_d       = LOCK;
        x_d         = h_cnt_next_c;
        y_d         = v_cnt_next_c;
        frame_cnt_d = frame_cnt_q;
        if (!LOCK) begin
            frame_cnt_d = '0;
        end else if (v_wrap_c) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
        de_d          = run_d && (h_phase_next_c == PH_ACT) && (v_phase_next_c == PH_ACT);
        hsync_d       = (run_d && (h_phase_next_c == PH_SYN)) ? HS_POL : ~HS_POL;
        vsync_d       = (run_d && (v_phase_next_c == PH_SYN)) ? VS_POL : ~VS_POL;
        line_start_d  = run_d && (x_d == '0);
        frame_start_d = line_start_d && (y_d == '0);
    end

    // Run flag and registered outputs.
    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            run_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            run_q         <= run_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_480p.sv
// Directed bench: full-size raster for the first lines and lock handling, plus a
// small-raster instance for complete frames, VSYNC edges and FRAME_CNT wrap.
module tb_video_timing_480p;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       lock_d, lock_s;

    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 pclk = ~pclk;

    video_timing_480p u_dut (
        .PCLK        (pclk),
        .RESET_n     (rst_n),
        .LOCK        (lock_d),
        .HSYNC       (d_hs),
        .VSYNC       (d_vs),
        .DE          (d_de),
        .X           (d_x),
        .Y           (d_y),
        .LINE_START  (d_ls),
        .FRAME_START (d_fs),
        .FRAME_CNT   (d_fc)
    );

    // 7x5 raster: H ACT 0..3, FP 4, SYN 5, BP 6; V ACT 0..1, FP 2, SYN 3, BP 4.
    video_timing_480p #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_small (
        .PCLK        (pclk),
        .RESET_n     (rst_n),
        .LOCK        (lock_s),
        .HSYNC       (s_hs),
        .VSYNC       (s_vs),
        .DE          (s_de),
        .X           (s_x),
        .Y           (s_y),
        .LINE_START  (s_ls),
        .FRAME_START (s_fs),
        .FRAME_CNT   (s_fc)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic chk_d(input int ex, input int ey, input int ede, input int ehs,
                         input int evs, input int els, input int efs, input int efc);
        chk("d_x", d_x, ex);
        chk("d_y", d_y, ey);
        chk("d_de", d_de, ede);
        chk("d_hsync", d_hs, ehs);
        chk("d_vsync", d_vs, evs);
        chk("d_line_start", d_ls, els);
        chk("d_frame_start", d_fs, efs);
        chk("d_frame_cnt", d_fc, efc);
    endtask

    task automatic chk_s(input int ex, input int ey, input int ede, input int ehs,
                         input int evs, input int els, input int efs, input int efc);
        chk("s_x", s_x, ex);
        chk("s_y", s_y, ey);
        chk("s_de", s_de, ede);
        chk("s_hsync", s_hs, ehs);
        chk("s_vsync", s_vs, evs);
        chk("s_line_start", s_ls, els);
        chk("s_frame_start", s_fs, efs);
        chk("s_frame_cnt", s_fc, efc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time budget expired");
        $fatal(1);
    end

    initial begin
        int de_cnt, hs_low, hs_tog, last_ls, fs_seen, vs_low;
        logic prev_hs, prev_vs;

        rst_n  = 1'b0;
        lock_d = 1'b0;
        lock_s = 1'b0;
        repeat (3) @(negedge pclk);
        chk_d(0, 0, 0, 1, 1, 0, 0, 0);
        chk_s(0, 0, 0, 1, 1, 0, 0, 0);
        rst_n = 1'b1;

        // LOCK low after reset: both instances stay idle.
        for (int k = 0; k < 100; k++) begin
            @(negedge pclk);
            chk_d(0, 0, 0, 1, 1, 0, 0, 0);
            chk_s(0, 0, 0, 1, 1, 0, 0, 0);
        end

        // Start of run on the full-size raster, then three complete lines.
        lock_d = 1'b1;
        @(negedge pclk);
        de_cnt  = 0;
        hs_low  = 0;
        hs_tog  = 0;
        last_ls = -1;
        prev_hs = d_hs;
        for (int k = 0; k < 3 * 800; k++) begin
            int ex, ey;
            ex = k % 800;
            ey = k / 800;
            chk_d(ex, ey, int'(ex < 640), int'(!(ex >= 656 && ex < 752)), 1,
                  int'(ex == 0), int'(ex == 0 && ey == 0), 0);
            de_cnt += int'(d_de);
            hs_low += int'(!d_hs);
            if (d_hs != prev_hs) hs_tog++;
            prev_hs = d_hs;
            if (d_ls) begin
                if (last_ls >= 0) chk("d_line_period", k - last_ls, 800);
                last_ls = k;
            end
            @(negedge pclk);
        end
        chk("d_de_cycles_3_lines", de_cnt, 1920);
        chk("d_hsync_low_3_lines", hs_low, 288);
        chk("d_hsync_toggles_3_lines", hs_tog, 6);

        // Drop LOCK mid-line, hold idle, then re-lock.
        repeat (300) @(negedge pclk);
        chk("d_x_before_drop", d_x, 300);
        chk("d_y_before_drop", d_y, 3);
        lock_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            chk_d(0, 0, 0, 1, 1, 0, 0, 0);
        end
        lock_d = 1'b1;
        @(negedge pclk);
        chk_d(0, 0, 1, 1, 1, 1, 1, 0);
        @(negedge pclk);
        chk_d(1, 0, 1, 1, 1, 0, 0, 0);

        // Small raster: 257 full frames plus one cycle.
        lock_s = 1'b1;
        @(negedge pclk);
        de_cnt  = 0;
        hs_low  = 0;
        vs_low  = 0;
        fs_seen = 0;
        prev_vs = s_vs;
        for (int k = 0; k < 257 * 35 + 1; k++) begin
            int ex, ey, ef;
            ex = k % 7;
            ey = (k / 7) % 5;
            ef = (k / 35) % 256;
            chk_s(ex, ey, int'(ex < 4 && ey < 2), int'(ex != 5), int'(ey != 3),
                  int'(ex == 0), int'(ex == 0 && ey == 0), ef);
            de_cnt += int'(s_de);
            hs_low += int'(!s_hs);
            vs_low += int'(!s_vs);
            if (prev_vs && !s_vs) begin
                chk("s_vsync_fall_x", s_x, 0);
                chk("s_vsync_fall_y", s_y, 3);
            end
            if (!prev_vs && s_vs) begin
                chk("s_vsync_rise_x", s_x, 0);
                chk("s_vsync_rise_y", s_y, 4);
            end
            prev_vs = s_vs;
            if (s_fs) fs_seen++;
            @(negedge pclk);
        end
        chk("s_de_cycles", de_cnt, 2057);
        chk("s_hsync_low_cycles", hs_low, 1285);
        chk("s_vsync_low_cycles", vs_low, 1799);
        chk("s_frame_starts", fs_seen, 258);
        chk("s_frame_cnt_after_wrap", s_fc, 1);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk_d(0, 0, 0, 1, 1, 0, 0, 0);
        chk_s(0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge pclk);
        chk_d(0, 0, 0, 1, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_480p.md
Name: video_timing_480p

Overview:
Raster timing generator directly downstream of the 25.2 MHz pixel-clock PLL. It consumes PCLK and the PLL lock indication. It produces HSYNC, VSYNC, data-enable, pixel coordinates and line/frame strobes for 640x480@60 Hz, with an 800x525 total raster. Pixel sources and the sync output pins are driven from these registered outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HSYNC active level (0 = active-low)
VS_POL, 0, VSYNC active level (0 = active-low)

Ports:
PCLK  in  1  pixel clock, 25.2 MHz; the single clock of the block
RESET_n  in  1  reset; asynchronous, active-low
LOCK  in  1  PLL lock, synchronous to PCLK; raster runs only while 1
HSYNC  out  1  horizontal sync, polarity HS_POL
VSYNC  out  1  vertical sync, polarity VS_POL
DE  out  1  high while the current pixel is in the visible area
X  out  10  current horizontal position, 0..H_TOTAL-1
Y  out  10  current line, 0..V_TOTAL-1
LINE_START  out  1  one-cycle pulse at X=0 of every line
FRAME_START  out  1  one-cycle pulse at X=0, Y=0
FRAME_CNT  out  8  frame counter, wraps modulo 256

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Elaboration error if either total exceeds 1024.
- Reset (RESET_n=0, asynchronous) gives the idle state:
  - X=0, Y=0, DE=0, LINE_START=0, FRAME_START=0, FRAME_CNT=0.
  - HSYNC=~HS_POL, VSYNC=~VS_POL (both deasserted).
- Run control:
  - Internal run flag is cleared by reset and set on the first PCLK edge that samples LOCK=1.
  - While the flag is 0, all outputs hold the idle values.
- Start of run (edge that samples LOCK=1 from idle):
  - Outputs show X=0, Y=0, DE=1, LINE_START=1, FRAME_START=1, FRAME_CNT=0.
  - X advances by 1 per PCLK from there.
- LOCK drop mid-run:
  - The next edge returns the block to idle: counters to 0, FRAME_CNT to 0, syncs deasserted.
  - On re-lock the raster restarts at 0,0.
- Horizontal phase FSM, decoded from X:
  - H_ACT for X 0..639.
  - H_FP for X 640..655.
  - H_SYN for X 656..751.
  - H_BP for X 752..799.
  - X=H_TOTAL-1 wraps to 0, and Y advances on that same edge.
- Vertical phase FSM, decoded from Y, advancing only at line wrap:
  - V_ACT for Y 0..479.
  - V_FP for Y 480..489.
  - V_SYN for Y 490..491.
  - V_BP for Y 492..524.
  - Y=V_TOTAL-1 at the X wrap goes to 0, and FRAME_CNT increments on that same edge (255 wraps to 0).
- Output decode:
  - All outputs are flops; no combinational decode reaches a port.
  - Every output in a given cycle is consistent with X/Y in that same cycle. Decodes are computed from next-state values.
  - DE = (X<H_ACTIVE) and (Y<V_ACTIVE).
  - HSYNC is active iff the horizontal phase is H_SYN, on every line including blanking lines.
  - VSYNC is active iff the vertical phase is V_SYN. Its edges align with X=0.
  - LINE_START = (X==0). FRAME_START = (X==0 and Y==0).
- Latency: fixed; one clock from LOCK sample to first active pixel.

Decomposition:
- Shared package video_timing_pkg holds:
  - the 480p default constants;
  - H_TOTAL/V_TOTAL functions;
  - the phase enum {ACT, FP, SYN, BP};
  - the polarity constants.
- One sub-module, timing_axis_counter:
  - generic wrap counter with phase decode;
  - parameterised by ACTIVE/FP/SYNC/BP;
  - inputs: advance enable and clear;
  - outputs: next-count, next-phase and wrap.
  - Instantiated twice: H uses advance=run; V uses advance=H wrap.

Test Plan:
- Reset with LOCK=0 for 100 cycles -> X=0, Y=0, DE=0, HSYNC=1, VSYNC=1, strobes 0 throughout.
- Raise LOCK -> next cycle X=0, Y=0, DE=1, FRAME_START=1; LINE_START period exactly 800 cycles; DE high 640 cycles/line on Y<480.
- HSYNC check -> low exactly for X 656..751 (96 cycles) on every line, lines 480..524 included; never toggles elsewhere.
- Full frame -> frame period 420000 cycles; DE count 307200; VSYNC low 1600 cycles, falling at X=0,Y=490 and rising at X=0,Y=492; FRAME_CNT 0->1 at the next FRAME_START.
- Small overrides (ACTIVE 4/2, porches 1, syncs 1), 257 frames -> FRAME_CNT steps 0..255 then 0; all phase boundaries match the decode rules.
- Drop LOCK at X=300, Y=200 -> next cycle idle values, FRAME_CNT=0; re-raise LOCK -> restart at 0,0 with FRAME_START=1; assert RESET_n mid-line -> idle immediately, asynchronously.
